// File: rtl/square_stream_checker_pkg.sv
// Shared types and constants for the square-sequence stream checker.
package square_stream_checker_pkg;

    localparam int unsigned NDefault    = 23;
    localparam int unsigned CntWDefault = 16;

    typedef enum logic [1:0] {
        StSeek  = 2'd0,
        StTrack = 2'd1,
        StHalt  = 2'd2
    } state_e;

    localparam logic [2:0] SelPassCnt   = 3'd0;
    localparam logic [2:0] SelFailCnt   = 3'd1;
    localparam logic [2:0] SelIdx       = 3'd2;
    localparam logic [2:0] SelFailIdx   = 3'd3;
    localparam logic [2:0] SelFailDataH = 3'd4;
    localparam logic [2:0] SelFailDataL = 3'd5;
    localparam logic [2:0] SelStatus    = 3'd6;
    localparam logic [2:0] SelExpHi     = 3'd7;

endpackage

// File: rtl/sq_seq_gen.sv
// Incremental generator of k^2 mod 2^N: exp accumulates successive odd numbers.
module sq_seq_gen
    import square_stream_checker_pkg::*;
#(
    parameter int unsigned N = NDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         advance,
    output logic [N-1:0] exp,
    output logic [N-1:0] idx
);

    logic [N-1:0] exp_q, exp_d;
    logic [N-1:0] odd_q, odd_d;
    logic [N-1:0] idx_q, idx_d;

    always_comb begin
        exp_d = exp_q;
        odd_d = odd_q;
        idx_d = idx_q;
        if (init) begin
            exp_d = '0;
            odd_d = N'(1);
            idx_d = '0;
        end else if (advance) begin
            exp_d = exp_q + odd_q;
            odd_d = odd_q + N'(2);
            idx_d = idx_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q <= '0;
            odd_q <= N'(1);
            idx_q <= '0;
        end else begin
            exp_q <= exp_d;
            odd_q <= odd_d;
            idx_q <= idx_d;
        end
    end

    assign exp = exp_q;
    assign idx = idx_q;

endmodule

// File: rtl/square_stream_checker.sv
// Checks a squarer result stream against k^2 mod 2^N; counts passes and fails,
// captures the first mismatch and exposes a registered status view.
module square_stream_checker
    import square_stream_checker_pkg::*;
#(
    parameter int unsigned N     = NDefault,
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         res_valid,
    input  logic [N-1:0] res_data,
    input  logic         clr,
    input  logic         stop_on_fail,
    input  logic [2:0]   sel,
    output logic [15:0]  dout,
    output logic         err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [N-1:0]       fail_idx_q, fail_idx_d;
    logic [N-1:0]       fail_data_q, fail_data_d;
    logic               err_q, err_d;
    logic [15:0]        dout_q, dout_d;

    logic               gen_init, gen_advance;
    logic [N-1:0]       exp, idx;
    logic               match;

    sq_seq_gen #(
        .N (N)
    ) u_seq_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (gen_init),
        .advance (gen_advance),
        .exp     (exp),
        .idx     (idx)
    );

    assign match = (res_data == exp);

    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_idx_d  = fail_idx_q;
        fail_data_d = fail_data_q;
        err_d       = err_q;
        gen_init    = 1'b0;
        gen_advance = 1'b0;
        if (clr) begin
            state_d     = StSeek;
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            fail_idx_d  = '0;
            fail_data_d = '0;
            err_d       = 1'b0;
            gen_init    = 1'b1;
        end else if (res_valid) begin
            unique case (state_q)
                StSeek: begin
                    if (res_data == '0) begin
                        if (pass_cnt_q != {CNT_W{1'b1}}) pass_cnt_d = pass_cnt_q + CNT_W'(1);
                        state_d     = StTrack;
                        gen_advance = 1'b1;
                    end
                end
                StTrack: begin
                    if (match) begin
                        if (pass_cnt_q != {CNT_W{1'b1}}) pass_cnt_d = pass_cnt_q + CNT_W'(1);
                        gen_advance = 1'b1;
                    end else begin
                        if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                        err_d = 1'b1;
                        if (!err_q) begin
                            fail_idx_d  = idx;
                            fail_data_d = res_data;
                        end
                        // Halting freezes the sequence at the failing index.
                        if (stop_on_fail) state_d = StHalt;
                        else              gen_advance = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dout_d = '0;
        unique case (sel)
            SelPassCnt:   dout_d = 16'(pass_cnt_q);
            SelFailCnt:   dout_d = 16'(fail_cnt_q);
            SelIdx:       dout_d = idx[15:0];
            SelFailIdx:   dout_d = fail_idx_q[15:0];
            SelFailDataH: dout_d = fail_data_q[N-1 -: 16];
            SelFailDataL: dout_d = fail_data_q[15:0];
            SelStatus:    dout_d = {12'b0, err_q, state_q, stop_on_fail};
            SelExpHi:     dout_d = exp[N-1 -: 16];
            default:      dout_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StSeek;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
            err_q       <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_idx_q  <= fail_idx_d;
            fail_data_q <= fail_data_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
        end
    end

    assign dout = dout_q;
    assign err  = err_q;

endmodule

// File: doc/square_stream_checker.md
SQUARE_STREAM_CHECKER -- requirements
Module: square_stream_checker

Interface
REQ-001 Parameter N, default 23: width of result word and index.
REQ-002 Parameter CNT_W, default 16: width of pass and fail counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 res_valid  in  1  one-cycle strobe: res_data holds a new squarer result.
REQ-007 res_data  in  N  squarer result, meaningful only when res_valid=1.
REQ-008 clr  in  1  synchronous soft clear: counters cleared, checker returns to SEEK.
REQ-009 stop_on_fail  in  1  when 1, first mismatch freezes the checker.
REQ-010 sel  in  3  selects the dout view.
REQ-011 dout  out  16  registered status view.
REQ-012 err  out  1  sticky: at least one mismatch since reset or clr.

Function
REQ-013 Expected stream: k^2 mod 2^N for k = 0,1,2,...; consecutive values are generated incrementally (exp += odd; odd += 2), all mod 2^N; no multiplier.
REQ-014 States: SEEK, TRACK, HALT.
REQ-015 SEEK: samples not equal to 0 are ignored, with no counter change; a sample equal to 0 counts as a pass and moves to TRACK with idx=1, exp=1, odd=3.
REQ-016 TRACK, per sample: compare all N bits of res_data with exp. Equal increments pass_cnt; unequal increments fail_cnt and sets err. Then exp, odd and idx advance.
REQ-017 First mismatch after reset or clr captures fail_idx=idx and fail_data=res_data; later mismatches do not overwrite the capture.
REQ-018 Mismatch with stop_on_fail=1 goes to HALT; the failing sample is still counted and captured.
REQ-019 HALT: samples ignored and all state frozen; HALT is left only by clr (to SEEK) or reset.
REQ-020 Counters saturate at 2^CNT_W-1; idx, exp and odd wrap mod 2^N.
REQ-021 res_valid on every consecutive cycle is supported with no lost sample.
REQ-022 clr and res_valid in the same cycle: clr wins and the sample is dropped.
REQ-023 dout = view(sel) registered, 1-cycle latency. Views: 0 pass_cnt; 1 fail_cnt; 2 idx[15:0]; 3 fail_idx[15:0]; 4 fail_data[N-1:N-16]; 5 fail_data[15:0]; 6 {12'b0, err, state[1:0], stop_on_fail}; 7 exp[N-1:N-16]. Counters are zero-extended or truncated to 16 bits.
REQ-024 State encoding: SEEK=0, TRACK=1, HALT=2.

Reset
REQ-025 rst_n=0 sets state=SEEK; pass_cnt, fail_cnt, idx, exp, fail_idx, fail_data, dout and err to 0; odd to 1.
REQ-026 Reset during any state, including HALT, takes effect on the next edge regardless of res_valid or clr.
REQ-027 clr has the same effect as reset on all registers except dout, which continues to track sel.

Structure
REQ-028 Shared package holds: N default, state enum, sel view codes.
REQ-029 One sub-module, sq_seq_gen, holds exp, odd and idx. Its ports are init, advance, exp and idx.
REQ-030 Compare, counters, capture, FSM and output mux are in the top module.

Verification
REQ-031 Reset, then feed 0,1,4,9,16 back-to-back -> pass_cnt=5, fail_cnt=0, err=0, state=TRACK, idx=5.
REQ-032 Feed 7,3,0,1 -> first two samples ignored; pass_cnt=2, idx=2.
REQ-033 stop_on_fail=0, feed 0,1,5,9 -> fail_cnt=1, fail_idx=2, fail_data=5, pass_cnt=3, err=1, state=TRACK.
REQ-034 stop_on_fail=1, feed 0,1,5,9 -> fail_cnt=1, pass_cnt=2, state=HALT; 9 is ignored and idx stays 2.
REQ-035 In HALT, clr and res_valid (data 0) in the same cycle -> state=SEEK, all counters 0, err=0; the next sample 0 makes pass_cnt=1.
REQ-036 Feed 0 then 65540 wrong samples -> fail_cnt saturates at 65535; sel=1 gives dout=0xFFFF one cycle later.
